ts_packet_arbiter: RTL
======================

Name: ts_packet_arbiter

Overview:
- Multiplexes the four per-channel reclocked TS input FIFOs into one byte stream in the SYS_CLK domain.
- Grants whole 188-byte packets round-robin to channels reporting GOT_FULL_PACKET, issues that channel's RD_REQ, and tags bytes with channel ID and packet boundaries.
- Applies downstream backpressure through a 2-entry output buffer.
- Sits between the per-channel input stages and the host transport (USB/Ethernet packetiser).

Parameters:
- NUM_CH, 4, number of input channels (CHAN_ID width = 2).
- PKT_LEN, 188, bytes per packet.
- SYNC_BYTE, 8'h47, expected first byte (used only with SYNC_CHECK_EN).

Ports:
- SYS_CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- GOT_FULL_PACKET  in  NUM_CH  per-channel "≥PKT_LEN bytes buffered".
- DATA_IN  in  8*NUM_CH  per-channel FIFO q; channel n at [8n+7:8n]; valid 1 cycle after RD_REQ[n].
- RD_REQ  out  NUM_CH  per-channel FIFO read strobe; one-hot or zero.
- OUT_READY  in  1  downstream accepts byte this cycle.
- DATA_OUT  out  8  output byte.
- DATA_VALID  out  1  DATA_OUT valid; transfer = DATA_VALID & OUT_READY.
- PKT_START  out  1  current byte is packet byte 0.
- PKT_END  out  1  current byte is packet byte PKT_LEN-1.
- CHAN_ID  out  2  source channel of current byte.
- SYNC_ERR  out  1  (SYNC_CHECK_EN only) 1-cycle pulse.
- SYNC_ERR_CNT  out  16  (SYNC_CHECK_EN only) saturating error count.

Behaviour:
- Reset: state IDLE; RD_REQ=0, DATA_VALID=0, DATA_OUT=0, PKT_START=0, PKT_END=0, CHAN_ID=0. Buffer and in-flight flag cleared. RR pointer = NUM_CH-1, so channel 0 has first priority.
- FSM states IDLE, READ, DRAIN, GAP.
- IDLE → READ: when any GOT_FULL_PACKET bit is set, grant the first set channel searching upward from (last_grant+1) mod NUM_CH. Latch grant, rd_cnt=0, update last_grant.
- READ:
  - RD_REQ[grant]=1 in a cycle only when (buffer occupancy after this cycle's pop) + in_flight < 2.
  - Each issued read sets in_flight for the next cycle and increments rd_cnt.
  - When the read with rd_cnt==PKT_LEN-1 issues → DRAIN.
- DRAIN: wait until in_flight==0 → GAP.
- GAP: exactly 2 cycles, letting the granted channel's GOT_FULL_PACKET settle, then → IDLE.
- A granted packet is never aborted or pre-empted; the arbiter does not re-check GOT_FULL_PACKET during READ.
- Capture: the cycle after a read, DATA_IN[grant] is pushed into the buffer with tags start=(byte idx 0), end=(idx PKT_LEN-1), chan=grant.
- Output buffer: 2-entry FIFO, head drives the outputs. Push and pop in the same cycle is legal. Never overflows by credit rule; an overflow is an assertion failure.
- Latency: RD_REQ → byte visible on DATA_OUT = 2 cycles when the buffer is empty.
- Throughput: 1 byte/cycle sustained with OUT_READY=1.
- Outputs are held stable while DATA_VALID & !OUT_READY.
- Reset mid-packet: everything returns to reset values. No partial-packet recovery; upstream FIFOs are also reset by RST.

Optional Feature:
- Macro SYNC_CHECK_EN.
- Defined: when a PKT_START byte is captured and its value ≠ SYNC_BYTE:
  - SYNC_ERR pulses 1 cycle.
  - SYNC_ERR_CNT increments, saturating at 16'hFFFF; reset value 0.
  - The packet is still forwarded unchanged.
- Undefined: SYNC_ERR and SYNC_ERR_CNT ports and all check logic are absent.

Decomposition:
- Shared package/defines: PKT_LEN, SYNC_BYTE, NUM_CH, state encodings (IDLE/READ/DRAIN/GAP), CHAN_ID width.
- One natural sub-module: ts_out_buffer, the 2-entry tagged FIFO (push, pop, occupancy, head outputs). The round-robin grant stays inline.

Test Plan:
- Single channel: GOT_FULL_PACKET=4'b0100, OUT_READY=1, FIFO 2 holds 0x47,0x01..: exactly 188 RD_REQ[2] pulses. 188 valid bytes with CHAN_ID=2, PKT_START on 0x47, PKT_END on byte 187. First byte appears 2 cycles after the first RD_REQ.
- All four full continuously: grant order 0,1,2,3,0. Every packet 188 contiguous bytes, no interleaving. Exactly 2 GAP cycles + DRAIN between packets.
- Backpressure: OUT_READY toggles 1,0,0,1 repeatedly mid-packet:
  - no byte lost or duplicated (compare to source sequence);
  - RD_REQ never issued when the buffer holds 2 entries;
  - outputs held while stalled.
- Simultaneous requests after channel 3 served: GOT_FULL_PACKET=4'b1011 → grant 0, then 1, then 3.
- Reset mid-packet at byte 100: all outputs return to 0 next edge. After release with GOT_FULL_PACKET=4'b0001, a fresh packet starts at rd_cnt 0 on channel 0.
- SYNC_CHECK_EN: packets starting 0x47, 0x46, 0x00 → SYNC_ERR pulses twice, SYNC_ERR_CNT=2, all three packets forwarded intact. Force the count to 16'hFFFE and send 3 bad packets → count stays at 16'hFFFF.

Source files
------------

// File: rtl/ts_packet_arbiter_pkg.sv
// Shared constants, state encodings, byte-tag payload and round-robin helper
// for the TS packet arbiter.
package ts_packet_arbiter_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CHAN_W  = 2;
  localparam int unsigned PKT_LEN = 188;
  localparam int unsigned CNT_W   = 8;

  localparam logic [7:0] SYNC_BYTE = 8'h47;

  // FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // One tagged byte as held in the output buffer
  typedef struct packed {
    logic [7:0]        data;
    logic              start;
    logic              last;
    logic [CHAN_W-1:0] chan;
  } ts_byte_t;

  // First requesting channel searching upward from last+1 (mod NUM_CH)
  function automatic logic [CHAN_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CHAN_W-1:0] last);
    logic [CHAN_W-1:0] pick;
    logic [CHAN_W-1:0] cand;
    logic              found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CHAN_W'((32'(last) + i) % NUM_CH);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ts_out_buffer.sv
// 2-entry tagged output FIFO. Slot 0 is the head and drives the registered
// outputs directly; slot 1 backs it up. Push and pop may coincide.
// Ports:
//   SYS_CLK, RST    clock, async active-low reset
//   push/push_data  write one tagged byte
//   pop             downstream accepted the head this cycle (ignored if empty)
//   head_valid/head registered head entry
//   occ_c           current occupancy (0..2)
module ts_out_buffer
  import ts_packet_arbiter_pkg::*;
(
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       push,
  input  ts_byte_t   push_data,
  input  logic       pop,
  output logic       head_valid,
  output ts_byte_t   head,
  output logic [1:0] occ_c
);

  ts_byte_t slot1;
  logic     v1;
  logic     pop_eff;

  assign pop_eff = pop & head_valid;
  assign occ_c   = {1'b0, head_valid} + {1'b0, v1};

  // Head is cleared when the buffer empties so idle outputs read as zero
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      head_valid <= 1'b0;
      head       <= '0;
      v1         <= 1'b0;
      slot1      <= '0;
    end else begin
      unique case ({v1, head_valid})
        2'b00: begin
          if (push) begin
            head       <= push_data;
            head_valid <= 1'b1;
          end
        end
        2'b01: begin
          if (pop_eff) begin
            if (push) begin
              head <= push_data;
            end else begin
              head       <= '0;
              head_valid <= 1'b0;
            end
          end else if (push) begin
            slot1 <= push_data;
            v1    <= 1'b1;
          end
        end
        2'b11: begin
          if (pop_eff) begin
            head <= slot1;
            if (push) begin
              slot1 <= push_data;
            end else begin
              slot1 <= '0;
              v1    <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The read-credit rule in the arbiter must keep the buffer from overflowing
  assert property (@(posedge SYS_CLK) disable iff (!RST) !(push && v1 && !pop_eff));

endmodule

// File: rtl/ts_packet_arbiter.sv
// Round-robin arbiter merging four TS input FIFOs into one tagged byte
// stream. Whole 188-byte packets are granted; reads are credit-limited so
// the 2-entry output buffer never overflows.
// Optional feature: define SYNC_CHECK_EN to flag packets whose first byte
// is not the sync byte (SYNC_ERR pulse + saturating SYNC_ERR_CNT).
// Ports:
//   SYS_CLK, RST         clock, async active-low reset
//   GOT_FULL_PACKET      per-channel "full packet buffered"
//   DATA_IN              per-channel FIFO data, channel n at [8n+7:8n]
//   RD_REQ               per-channel FIFO read strobe (combinational, one-hot)
//   OUT_READY            downstream accepts a byte this cycle
//   DATA_OUT/DATA_VALID  output byte and valid
//   PKT_START/PKT_END    first / last byte of a packet
//   CHAN_ID              source channel of the current byte
//   SYNC_ERR/_CNT        sync-byte error pulse and count (SYNC_CHECK_EN)
module ts_packet_arbiter
  import ts_packet_arbiter_pkg::*;
(
  input  logic                SYS_CLK,
  input  logic                RST,
  input  logic [NUM_CH-1:0]   GOT_FULL_PACKET,
  input  logic [8*NUM_CH-1:0] DATA_IN,
  output logic [NUM_CH-1:0]   RD_REQ,
  input  logic                OUT_READY,
  output logic [7:0]          DATA_OUT,
  output logic                DATA_VALID,
  output logic                PKT_START,
  output logic                PKT_END,
  output logic [CHAN_W-1:0]   CHAN_ID
`ifdef SYNC_CHECK_EN
  ,
  output logic                SYNC_ERR,
  output logic [15:0]         SYNC_ERR_CNT
`endif
);

  logic [1:0]        state_q, state_d;
  logic [CHAN_W-1:0] grant_q, grant_d;
  logic [CHAN_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              gap_q, gap_d;
  logic              in_flight_q, if_start_q, if_last_q;
  logic              rd_issue_c;

  logic              pop_c;
  logic [1:0]        occ_c, occ_after_pop_c;
  logic              credit_ok_c;
  logic [7:0]        cap_data_c;
  ts_byte_t          push_data_c;
  ts_byte_t          head;

  // Credit: entries left after this cycle's pop plus the read still in flight
  assign pop_c           = DATA_VALID & OUT_READY;
  assign occ_after_pop_c = occ_c - {1'b0, pop_c};
  assign credit_ok_c     = ({1'b0, occ_after_pop_c} + {2'b00, in_flight_q}) < 3'd2;

  // Next-state and read issue
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rd_cnt_d   = rd_cnt_q;
    gap_d      = gap_q;
    rd_issue_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|GOT_FULL_PACKET) begin
          grant_d  = rr_pick(GOT_FULL_PACKET, last_q);
          last_d   = grant_d;
          rd_cnt_d = '0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok_c) begin
          rd_issue_c = 1'b1;
          rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == CNT_W'(PKT_LEN - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!in_flight_q) begin
          state_d = ST_GAP;
          gap_d   = 1'b0;
        end
      end
      ST_GAP: begin
        // Two cycles so the served channel's GOT_FULL_PACKET can drop
        gap_d = 1'b1;
        if (gap_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and read-pipeline registers
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= CHAN_W'(NUM_CH - 1);
      rd_cnt_q    <= '0;
      gap_q       <= 1'b0;
      in_flight_q <= 1'b0;
      if_start_q  <= 1'b0;
      if_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      rd_cnt_q    <= rd_cnt_d;
      gap_q       <= gap_d;
      in_flight_q <= rd_issue_c;
      if_start_q  <= rd_issue_c & (rd_cnt_q == '0);
      if_last_q   <= rd_issue_c & (rd_cnt_q == CNT_W'(PKT_LEN - 1));
    end
  end

  assign RD_REQ = rd_issue_c ? (NUM_CH'(1) << grant_q) : '0;

  // FIFO data is valid the cycle after its read strobe
  assign cap_data_c        = DATA_IN[{grant_q, 3'b000} +: 8];
  assign push_data_c.data  = cap_data_c;
  assign push_data_c.start = if_start_q;
  assign push_data_c.last  = if_last_q;
  assign push_data_c.chan  = grant_q;

  ts_out_buffer u_out_buffer (
    .SYS_CLK    (SYS_CLK),
    .RST        (RST),
    .push       (in_flight_q),
    .push_data  (push_data_c),
    .pop        (OUT_READY),
    .head_valid (DATA_VALID),
    .head       (head),
    .occ_c      (occ_c)
  );

  assign DATA_OUT  = head.data;
  assign PKT_START = head.start;
  assign PKT_END   = head.last;
  assign CHAN_ID   = head.chan;

`ifdef SYNC_CHECK_EN
  logic        sync_bad_c;
  logic        sync_err_q;
  logic [15:0] sync_err_cnt_q;

  assign sync_bad_c = in_flight_q & if_start_q & (cap_data_c != SYNC_BYTE);

  // Error pulse and saturating count; data is forwarded regardless
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      sync_err_q     <= 1'b0;
      sync_err_cnt_q <= '0;
    end else begin
      sync_err_q <= sync_bad_c;
      if (sync_bad_c && (sync_err_cnt_q != 16'hFFFF)) begin
        sync_err_cnt_q <= sync_err_cnt_q + 16'd1;
      end
    end
  end

  assign SYNC_ERR     = sync_err_q;
  assign SYNC_ERR_CNT = sync_err_cnt_q;
`endif

endmodule
